// File: rtl/level_gen.sv
// level_gen: rebuilds a clean registered level from single-cycle request pulses.
//
// A `rise` pulse drives `a` high and a `down` pulse drives it low, one cycle
// after the request. Each new level is held for a minimum number of cycles
// (MIN_HIGH after going high, MIN_LOW after going low). An opposite request
// that arrives during the hold is queued and applied as soon as the hold
// expires. A request matching the current level cancels a queued toggle.
// Simultaneous rise and down requests are ignored and reported on `err`.
//
// Handshake: there is no ready/backpressure. `rise` and `down` are request
// pulses sampled on every rising clock edge. A request is accepted in the
// cycle it is high. It either acts at once, or is queued (`pend`), or is
// ignored.
//
// Parameters:
//   MIN_HIGH : minimum cycles `a` stays 1 after rising  (1 .. 2**CW)
//   MIN_LOW  : minimum cycles `a` stays 0 after falling (1 .. 2**CW)
//   CW       : hold counter width
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active high
//   rise : request to drive `a` high
//   down : request to drive `a` low
//   a    : generated level (registered)
//   busy : minimum-time hold active, i.e. hold counter nonzero (registered)
//   pend : an opposite request is queued (registered)
//   err  : one-cycle pulse after a cycle with rise and down both high (registered)

module level_gen #(
  parameter int MIN_HIGH = 4,
  parameter int MIN_LOW  = 4,
  parameter int CW       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rise,
  input  logic down,
  output logic a,
  output logic busy,
  output logic pend,
  output logic err
);

  // State bit 1 is the level and state bit 0 is the hold flag. Because of
  // this encoding, `a` and `busy` come straight from flops.
  typedef enum logic [1:0] {
    LOW_IDLE  = 2'b00,
    LOW_HOLD  = 2'b01,
    HIGH_IDLE = 2'b10,
    HIGH_HOLD = 2'b11
  } state_t;

  // Counter reload values. The counter holds the remaining extra cycles,
  // so a minimum time of 1 means no hold at all.
  localparam logic [CW-1:0] HIGH_LOAD = CW'(MIN_HIGH - 1);
  localparam logic [CW-1:0] LOW_LOAD  = CW'(MIN_LOW - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            err_q, err_d;

  logic            level;
  logic            cnt_zero;
  logic [CW-1:0]   cnt_dec;
  logic            conflict;
  logic            req_high;
  logic            req_low;
  logic            req_opp;
  logic            req_same;
  logic            next_level;

  // Request decode
  always_comb begin
    level    = state_q[1];
    cnt_zero = (cnt_q == '0);
    conflict = rise & down;
    // A conflicting cycle counts as "no request" for the level logic.
    req_high = rise & ~down;
    req_low  = down & ~rise;
    req_opp  = level ? req_low  : req_high;
    req_same = level ? req_high : req_low;
    // The counter saturates at zero.
    cnt_dec  = cnt_zero ? '0 : (cnt_q - CW'(1));
  end

  // Next-state logic
  always_comb begin
    next_level = level;
    cnt_d      = cnt_dec;
    pend_d     = pend_q;
    err_d      = conflict;

    if (pend_q && req_same) begin
      // A request back to the current level withdraws the queued toggle.
      // This takes priority even when the hold has just expired.
      pend_d = 1'b0;
    end else if (cnt_zero && (pend_q || req_opp)) begin
      // Toggle. Load the hold for the new level and clear any queued request.
      next_level = ~level;
      cnt_d      = level ? LOW_LOAD : HIGH_LOAD;
      pend_d     = 1'b0;
    end else if (req_opp) begin
      // Opposite request during the hold: queue it. A second queued
      // request is absorbed because pend is already set.
      pend_d = 1'b1;
    end

    case ({next_level, (cnt_d != '0)})
      2'b00:   state_d = LOW_IDLE;
      2'b01:   state_d = LOW_HOLD;
      2'b10:   state_d = HIGH_IDLE;
      default: state_d = HIGH_HOLD;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOW_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  // All outputs are flop outputs. There is no input-to-output path.
  assign a    = state_q[1];
  assign busy = state_q[0];
  assign pend = pend_q;
  assign err  = err_q;

endmodule

// File: tb/tb_level_gen.sv
// tb_level_gen: randomized and directed test of level_gen against a
// behavioural model.
//
// Two instances are driven by the same stimulus:
//   dut0 : MIN_HIGH=4, MIN_LOW=4, CW=8
//   dut1 : MIN_HIGH=1, MIN_LOW=3, CW=4 (no high hold, asymmetric times)
//
// The model tracks the level, the cycle of the last toggle, a pending flag
// and the last conflict. It decides the hold from elapsed cycles, not from a
// down-counter. Expected outputs for each cycle are queued in exp_q and
// compared at the falling edge.

module tb_level_gen;

  // Clock and reset
  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rise = 1'b0;
  logic down = 1'b0;

  always #5 clk = ~clk;

  logic a_s[2];
  logic busy_s[2];
  logic pend_s[2];
  logic err_s[2];

  level_gen #(.MIN_HIGH(4), .MIN_LOW(4), .CW(8)) dut0 (
    .clk  (clk),
    .rst  (rst),
    .rise (rise),
    .down (down),
    .a    (a_s[0]),
    .busy (busy_s[0]),
    .pend (pend_s[0]),
    .err  (err_s[0])
  );

  level_gen #(.MIN_HIGH(1), .MIN_LOW(3), .CW(4)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .rise (rise),
    .down (down),
    .a    (a_s[1]),
    .busy (busy_s[1]),
    .pend (pend_s[1]),
    .err  (err_s[1])
  );

  // Scoreboard
  int n_checks = 0;
  int n_errors = 0;

  // Each entry is {a, busy, pend, err}: first the entry for dut0, then dut1.
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  // Behavioural model
  int min_hi[2] = '{4, 1};
  int min_lo[2] = '{4, 3};
  bit m_level[2];
  bit m_pend[2];
  bit m_err[2];
  int m_t0[2];     // cycle in which the current level first appeared
  int cyc = 0;     // model cycle index

  function automatic int min_of(int i);
    return m_level[i] ? min_hi[i] : min_lo[i];
  endfunction

  // The level must stay for min_of(i) cycles: t0 .. t0+min-1. Busy is high
  // in every one of those cycles except the last.
  function automatic bit hold_active(int i);
    return (cyc - m_t0[i]) < (min_of(i) - 1);
  endfunction

  task automatic push_expected();
    for (int i = 0; i < 2; i++)
      exp_q.push_back({m_level[i], hold_active(i), m_pend[i], m_err[i]});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_level[i] = 1'b0;
      m_pend[i]  = 1'b0;
      m_err[i]   = 1'b0;
      m_t0[i]    = -100000;
    end
    exp_q.delete();
    push_expected();
  endtask

  // Applies the inputs of the current cycle, then moves to the next cycle.
  task automatic model_advance(input bit r, input bit d);
    bit conf, opp, same, free;
    for (int i = 0; i < 2; i++) begin
      conf = r & d;
      opp  = !conf && (m_level[i] ? d : r);
      same = !conf && (m_level[i] ? r : d);
      free = !hold_active(i);
      m_err[i] = conf;
      if (m_pend[i] && same) begin
        m_pend[i] = 1'b0;
      end else if (free && (m_pend[i] || opp)) begin
        m_level[i] = !m_level[i];
        m_t0[i]    = cyc + 1;
        m_pend[i]  = 1'b0;
      end else if (opp) begin
        m_pend[i] = 1'b1;
      end
    end
    cyc++;
    push_expected();
  endtask

  task automatic compare_all();
    logic [3:0] e;
    for (int i = 0; i < 2; i++) begin
      if (exp_q.size() == 0) begin
        check($sformatf("exp_q_empty%0d", i), 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("a%0d", i),    a_s[i],    e[3]);
        check($sformatf("busy%0d", i), busy_s[i], e[2]);
        check($sformatf("pend%0d", i), pend_s[i], e[1]);
        check($sformatf("err%0d", i),  err_s[i],  e[0]);
      end
    end
  endtask

  // Driver tasks. Both are called at a falling edge and return at a falling
  // edge with the outputs of the new cycle already compared.
  task automatic step(input logic r, input logic d);
    rise = r;
    down = d;
    model_advance(r, d);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0);
  endtask

  // Reset is asserted between clock edges. The outputs must clear at once,
  // without waiting for a clock.
  task automatic do_reset();
    rise = 1'b0;
    down = 1'b0;
    rst  = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_a%0d", i),    a_s[i],    1'b0);
      check($sformatf("rst_busy%0d", i), busy_s[i], 1'b0);
      check($sformatf("rst_pend%0d", i), pend_s[i], 1'b0);
      check($sformatf("rst_err%0d", i),  err_s[i],  1'b0);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all();
  endtask

  // Main sequence
  initial begin
    @(negedge clk);
    do_reset();

    // Rise, minimum high time, then fall
    step(1, 0);                   // cycle 1
    check("t1_a_c1", a_s[0], 1'b1);
    check("t1_busy_c1", busy_s[0], 1'b1);
    idle(2);                      // cycle 3
    check("t1_busy_c3", busy_s[0], 1'b1);
    idle(1);                      // cycle 4
    check("t1_a_c4", a_s[0], 1'b1);
    check("t1_busy_c4", busy_s[0], 1'b0);
    step(0, 1);                   // cycle 5
    check("t1_a_c5", a_s[0], 1'b0);
    idle(4);

    // Pending down applied when the high hold expires
    step(1, 0);                   // cycle 1
    step(0, 0);                   // cycle 2
    step(0, 1);                   // cycle 3
    check("t2_pend_c3", pend_s[0], 1'b1);
    idle(1);                      // cycle 4
    check("t2_a_c4", a_s[0], 1'b1);
    idle(1);                      // cycle 5
    check("t2_a_c5", a_s[0], 1'b0);
    check("t2_pend_c5", pend_s[0], 1'b0);
    check("t2_busy_c5", busy_s[0], 1'b1);
    idle(4);

    // Queued down cancelled by a rise
    step(1, 0);                   // cycle 1
    step(0, 1);                   // cycle 2
    check("t3_pend_c2", pend_s[0], 1'b1);
    step(1, 0);                   // cycle 3
    check("t3_pend_c3", pend_s[0], 1'b0);
    idle(7);                      // cycle 10
    check("t3_a_c10", a_s[0], 1'b1);
    check("t3_busy_c10", busy_s[0], 1'b0);
    step(0, 1);
    idle(4);

    // Conflicts while idle low, including back-to-back
    step(1, 1);
    check("t4_err_single", err_s[0], 1'b1);
    check("t4_a_low", a_s[0], 1'b0);
    idle(1);
    check("t4_err_clear", err_s[0], 1'b0);
    step(1, 1);
    step(1, 1);
    check("t4_err_b2b", err_s[0], 1'b1);
    idle(1);

    // Requests that match the current level
    step(0, 1);
    check("t5_down_on_low", a_s[0], 1'b0);
    step(1, 0);
    idle(4);
    step(1, 0);
    check("t5_rise_on_high", a_s[0], 1'b1);
    check("t5_no_pend", pend_s[0], 1'b0);
    step(0, 1);
    idle(4);

    // Reset in the middle of a hold with a queued request
    step(1, 0);                   // cycle 1
    step(0, 1);                   // cycle 2: a=1, pend=1, counter 2
    check("t6_pend_pre", pend_s[0], 1'b1);
    do_reset();
    step(1, 0);
    check("t6_rise_after_rst", a_s[0], 1'b1);
    idle(4);

    // Random stimulus with occasional reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
